// File: rtl/apb_slv_responder.sv
// APB completer that turns each APB transfer into one valid/ready request to a
// local register file, returns its response with a single pready pulse, and
// completes stuck transfers with pslverr via a watchdog.

package apb_slv_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

endpackage

module apb_slv_responder
    import apb_slv_pkg::*;
#(
    parameter int abits   = 12,
    parameter int timeout = 64
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  apb_in_type       i_apbi,
    output apb_out_type      o_apbo,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic [abits-1:0] o_req_addr,
    output logic             o_req_write,
    output logic [31:0]      o_req_wdata,
    output logic [3:0]       o_req_wstrb,
    input  logic             i_resp_valid,
    input  logic [31:0]      i_resp_rdata,
    input  logic             i_resp_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_RESP = 2'd2,
        ACCEPT    = 2'd3
    } state_t;

    // A zero timeout still needs a legal one-bit counter even though it never expires.
    localparam int cw = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [cw-1:0] cnt_last = (timeout > 0) ? cw'(timeout - 1) : '0;
    localparam logic [cw-1:0] cnt_one  = cw'(1);

    state_t           state_r;
    logic [cw-1:0]    cnt_r;
    logic             drop_r;
    logic [abits-1:0] req_addr_r;
    logic             req_write_r;
    logic [31:0]      req_wdata_r;
    logic [3:0]       req_wstrb_r;
    logic             pready_r;
    logic [31:0]      prdata_r;
    logic             pslverr_r;
    logic             unused_s;

    // Transfer sequencing, watchdog, late-response tracking and all output registers.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            drop_r      <= 1'b0;
            req_addr_r  <= '0;
            req_write_r <= 1'b0;
            req_wdata_r <= 32'h0000_0000;
            req_wstrb_r <= 4'h0;
            pready_r    <= 1'b0;
            prdata_r    <= 32'h0000_0000;
            pslverr_r   <= 1'b0;
        end else begin
            pready_r <= 1'b0;
            // The first response after a timeout belongs to the abandoned request.
            if (drop_r && i_resp_valid) begin
                drop_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (i_apbi.pselx && !i_apbi.penable) begin
                        req_addr_r  <= i_apbi.paddr[abits-1:0];
                        req_write_r <= i_apbi.pwrite;
                        req_wdata_r <= i_apbi.pwdata;
                        req_wstrb_r <= i_apbi.pwrite ? i_apbi.pstrb : 4'h0;
                        state_r     <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (!drop_r && i_req_ready) begin
                        cnt_r   <= '0;
                        state_r <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (i_resp_valid) begin
                        prdata_r  <= req_write_r ? 32'h0000_0000 : i_resp_rdata;
                        pslverr_r <= i_resp_err;
                        pready_r  <= 1'b1;
                        state_r   <= ACCEPT;
                    end else if ((timeout != 0) && (cnt_r == cnt_last)) begin
                        prdata_r  <= 32'h0000_0000;
                        pslverr_r <= 1'b1;
                        drop_r    <= 1'b1;
                        pready_r  <= 1'b1;
                        state_r   <= ACCEPT;
                    end else begin
                        cnt_r <= cnt_r + cnt_one;
                    end
                end
                ACCEPT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_req_valid    = (state_r == REQUEST) && !drop_r;
    assign o_req_addr     = req_addr_r;
    assign o_req_write    = req_write_r;
    assign o_req_wdata    = req_wdata_r;
    assign o_req_wstrb    = req_wstrb_r;
    assign o_apbo.pready  = pready_r;
    assign o_apbo.prdata  = prdata_r;
    assign o_apbo.pslverr = pslverr_r;

    assign unused_s = ^{i_apbi.pprot, i_apbi.paddr[31:abits]};

endmodule

// File: tb/tb_apb_slv_responder.sv
// Directed bench for apb_slv_responder: a vector table of single transfers plus
// hand-written sequences for late-response drop, stray access phase and reset.

module tb_apb_slv_responder;
    import apb_slv_pkg::*;

    localparam int ABITS = 12;
    localparam int TMO   = 8;

    logic              clk = 1'b0;
    logic              nrst;
    apb_in_type        apbi;
    apb_out_type       apbo;
    logic              req_valid;
    logic              req_ready;
    logic [ABITS-1:0]  req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        int          rdy_cyc;
        int          rsp_cyc;
        logic [31:0] rdata;
        logic        err;
        logic [11:0] e_addr;
        logic [3:0]  e_wstrb;
        int          e_pcyc;
        logic [31:0] e_prdata;
        logic        e_err;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    apb_slv_responder #(.abits(ABITS), .timeout(TMO)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_apbi       (apbi),
        .o_apbo       (apbo),
        .o_req_valid  (req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (req_addr),
        .o_req_write  (req_write),
        .o_req_wdata  (req_wdata),
        .o_req_wstrb  (req_wstrb),
        .i_resp_valid (resp_valid),
        .i_resp_rdata (resp_rdata),
        .i_resp_err   (resp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; cycle 0 is the setup phase.
    task automatic run_vec(input int idx, input vec_t v);
        int          first_p = -1;
        int          pulses  = 0;
        int          hold_bad = 0;
        logic [31:0] p_data  = 32'h0;
        logic        p_err   = 1'b0;
        apbi.paddr   = v.paddr;
        apbi.pwrite  = v.wr;
        apbi.pwdata  = v.pwdata;
        apbi.pstrb   = v.pstrb;
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b0;
        resp_rdata   = v.rdata;
        resp_err     = v.err;
        for (int c = 0; c < 40; c++) begin
            if (apbo.pready === 1'b1) begin
                pulses++;
                if (first_p < 0) begin
                    first_p = c;
                    p_data  = apbo.prdata;
                    p_err   = apbo.pslverr;
                end
            end
            if (c == 1) begin
                chk($sformatf("v%0d_addr", idx), {20'h0, req_addr}, {20'h0, v.e_addr});
                chk($sformatf("v%0d_wstrb", idx), {28'h0, req_wstrb}, {28'h0, v.e_wstrb});
                chk($sformatf("v%0d_wdata", idx), req_wdata, v.pwdata);
                chk($sformatf("v%0d_write", idx), {31'h0, req_write}, {31'h0, v.wr});
            end
            if (c >= 1 && c <= v.rdy_cyc &&
                (req_valid !== 1'b1 || req_addr !== v.e_addr || req_wdata !== v.pwdata ||
                 req_wstrb !== v.e_wstrb || req_write !== v.wr)) begin
                hold_bad++;
            end
            if (c == v.rdy_cyc + 1 && req_valid !== 1'b0) begin
                hold_bad++;
            end
            if (first_p >= 0 && c == first_p + 2) begin
                break;
            end
            apbi.pselx   = !(first_p >= 0 && c > first_p);
            apbi.penable = apbi.pselx && (c >= 0);
            if (c == 0) begin
                apbi.penable = 1'b0;
            end
            req_ready  = (c == v.rdy_cyc);
            resp_valid = (v.rsp_cyc != 0) && (c == v.rsp_cyc);
            step();
        end
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        chk($sformatf("v%0d_pready_cycle", idx), 32'(first_p), 32'(v.e_pcyc));
        chk($sformatf("v%0d_prdata", idx), p_data, v.e_prdata);
        chk($sformatf("v%0d_pslverr", idx), {31'h0, p_err}, {31'h0, v.e_err});
        chk($sformatf("v%0d_pulses", idx), 32'(pulses), 32'd1);
        chk($sformatf("v%0d_req_hold", idx), 32'(hold_bad), 32'd0);
    endtask

    initial begin
        nrst       = 1'b0;
        apbi       = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;

        //          wr    paddr          pwdata         strb  rdy rsp rdata          err   e_addr  e_strb pcyc e_prdata       e_err
        vecs[0] = '{1'b1, 32'h0001_2008, 32'hA5A5_0001, 4'hF, 1,  2,  32'h5555_5555, 1'b0, 12'h008, 4'hF, 3,  32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0001_0004, 32'h1111_2222, 4'hF, 1,  2,  32'hDEAD_BEEF, 1'b0, 12'h004, 4'h0, 3,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'h3, 6,  7,  32'h0000_0000, 1'b0, 12'hFFC, 4'h3, 8,  32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 1,  4,  32'h0000_1234, 1'b1, 12'h020, 4'h0, 5,  32'h0000_1234, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0310, 32'h0000_0000, 4'hF, 1,  9,  32'hCAFE_0000, 1'b0, 12'h310, 4'h0, 10, 32'hCAFE_0000, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_37F0, 32'h0000_0000, 4'h0, 1,  2,  32'h0000_00A5, 1'b0, 12'h7F0, 4'h0, 3,  32'h0000_00A5, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1,  0,  32'hFFFF_FFFF, 1'b0, 12'h100, 4'h0, 10, 32'h0000_0000, 1'b1};

        step();
        step();
        nrst = 1'b1;
        chk("rst_pready", {31'h0, apbo.pready}, 32'h0);
        chk("rst_prdata", apbo.prdata, 32'h0);
        chk("rst_pslverr", {31'h0, apbo.pslverr}, 32'h0);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_req_fields", {req_addr, req_write, req_wstrb, 15'h0}, 32'h0);
        chk("rst_req_wdata", req_wdata, 32'h0);
        step();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // A timeout just happened: the next request must wait for the stale response.
        apbi.paddr   = 32'h0000_0044;
        apbi.pwrite  = 1'b0;
        apbi.pstrb   = 4'h0;
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b0;
        req_ready    = 1'b1;
        step();
        apbi.penable = 1'b1;
        chk("drop_hold1", {31'h0, req_valid}, 32'h0);
        step();
        chk("drop_hold2", {31'h0, req_valid}, 32'h0);
        resp_valid = 1'b1;
        resp_rdata = 32'hBAD0_BAD0;
        resp_err   = 1'b1;
        step();
        resp_valid = 1'b0;
        chk("drop_release", {31'h0, req_valid}, 32'h1);
        chk("stale_dropped", {31'h0, apbo.pready}, 32'h0);
        step();
        req_ready  = 1'b0;
        chk("drop_wait_valid", {31'h0, req_valid}, 32'h0);
        resp_valid = 1'b1;
        resp_rdata = 32'h600D_600D;
        resp_err   = 1'b0;
        step();
        resp_valid = 1'b0;
        chk("drop_next_pready", {31'h0, apbo.pready}, 32'h1);
        chk("drop_next_prdata", apbo.prdata, 32'h600D_600D);
        chk("drop_next_pslverr", {31'h0, apbo.pslverr}, 32'h0);
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        step();
        chk("drop_next_single", {31'h0, apbo.pready}, 32'h0);

        // Access phase with no preceding setup is ignored.
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stray_access_%0d", i), {30'h0, apbo.pready, req_valid}, 32'h0);
        end
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        step();

        // Reset while waiting for a response.
        apbi.paddr   = 32'h0000_00AB;
        apbi.pwrite  = 1'b1;
        apbi.pwdata  = 32'h7777_8888;
        apbi.pstrb   = 4'hF;
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b0;
        step();
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        step();
        req_ready = 1'b0;
        step();
        nrst = 1'b0;
        step();
        nrst         = 1'b1;
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        chk("mrst_pready", {31'h0, apbo.pready}, 32'h0);
        chk("mrst_prdata", apbo.prdata, 32'h0);
        chk("mrst_pslverr", {31'h0, apbo.pslverr}, 32'h0);
        chk("mrst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("mrst_req_fields", {req_addr, req_write, req_wstrb, 15'h0}, 32'h0);
        chk("mrst_req_wdata", req_wdata, 32'h0);
        resp_valid = 1'b1;
        resp_rdata = 32'h1357_9BDF;
        step();
        resp_valid = 1'b0;
        step();
        chk("mrst_no_spurious", {30'h0, apbo.pready, req_valid}, 32'h0);
        run_vec(7, vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slv_responder.md
# apb_slv_responder

Generic APB completer (slave-side) adapter for Bus[1] peripherals (UART1, PRCI, DMI, GPIO, DDR MGMT, PnP). It receives one `apb_in_type` slot from the Bus[1] APB vector and converts each APB transfer into a single valid/ready request toward a local register file. It then waits for that register file's response and returns `prdata`/`pslverr` with a one-cycle `pready` pulse. A watchdog completes transfers to unresponsive register files with `pslverr`.

## Interface
Parameters:
- `abits`, 12: width of the forwarded address offset. The Bus[1] window is 4 KB.
- `timeout`, 64: maximum cycles spent in WAIT_RESP. 0 disables the watchdog.

Ports:
- `i_clk`  in  1  clock. Single clock domain.
- `i_nrst`  in  1  reset. Synchronous, active-low.
- `i_apbi`  in  apb_in_type  APB request: `paddr`, `pprot`, `pselx`, `penable`, `pwrite`, `pwdata`, `pstrb`.
- `o_apbo`  out  apb_out_type  APB response: `pready`, `prdata`, `pslverr`.
- `o_req_valid`  out  1  request to the register file is valid.
- `i_req_ready`  in  1  register file accepts the request.
- `o_req_addr`  out  abits  `paddr[abits-1:0]`, latched at setup.
- `o_req_write`  out  1  latched `pwrite`.
- `o_req_wdata`  out  32  latched `pwdata`.
- `o_req_wstrb`  out  4  latched `pstrb`. Forced to 0 on reads.
- `i_resp_valid`  in  1  register file response strobe.
- `i_resp_rdata`  in  32  read data. Ignored on writes.
- `i_resp_err`  in  1  register file error flag.

## Operation
The block has four states: IDLE, REQUEST, WAIT_RESP, ACCEPT.
- **IDLE**
  - The block waits for an APB setup phase: `pselx=1` and `penable=0`.
  - On setup it latches addr, write, wdata and wstrb, then goes to REQUEST.
  - If `pselx=1` and `penable=1` arrive in IDLE (no setup seen), the block ignores them and does not assert `pready`.
- **REQUEST**
  - `o_req_valid=1` only when the `r_drop` flag is 0.
  - On `o_req_valid & i_req_ready` the block goes to WAIT_RESP.
  - Request fields stay stable while valid is high.
  - The request is never withdrawn.
- **WAIT_RESP**
  - On `i_resp_valid` the block latches rdata (forced to 0 for writes) and `err`, then goes to ACCEPT.
  - The watchdog counter runs in this state. When it reaches `timeout-1` without a response, the block:
    - latches `prdata=0` and `pslverr=1`,
    - sets `r_drop=1`,
    - goes to ACCEPT.
- **ACCEPT**
  - `pready=1` for exactly one cycle, with `prdata` and `pslverr` valid.
  - The block always returns to IDLE.
- **r_drop**
  - Set by a timeout.
  - Cleared by the next `i_resp_valid`. That late response is discarded and never reaches APB.
  - While `r_drop=1`, a new transfer may still be latched, but it waits in REQUEST with `o_req_valid=0`.
- **Other rules**
  - `i_resp_valid` is ignored in IDLE, REQUEST and ACCEPT, except when it clears `r_drop`.
  - If `i_resp_valid` and the watchdog expiry occur in the same cycle, the response wins: `pslverr=i_resp_err` and `r_drop` stays 0.
  - The watchdog counter is sized to `$clog2(timeout+1)` bits and resets to 0 on every entry to WAIT_RESP.

## Timing
- Reset (`i_nrst=0` at a rising edge) sets:
  - state to IDLE,
  - `pready=0`, `prdata=0`, `pslverr=0`,
  - `o_req_valid=0`, all `o_req_*` fields to 0,
  - `r_drop=0`, counter to 0.
- Reset in the middle of a transfer abandons it. No `pready` is issued.
- All outputs are registered, with no combinational path from `i_*` to `o_*`. `o_req_valid` is decoded directly from state flops.
- Minimum latency, with setup at cycle 0:
  - `o_req_valid=1` in cycles 1..n until `i_req_ready`.
  - With `i_req_ready` at cycle 1 and `i_resp_valid` at cycle 2, `pready=1` at cycle 3. This is 2 APB wait states.
- Timeout with `i_req_ready` at cycle 1 and no response: WAIT_RESP occupies cycles 2..timeout+1, and `pready`/`pslverr` rise at cycle `timeout+2`.
- `pready` is never high for two consecutive cycles.
- The earliest next setup phase is the cycle after ACCEPT.

## Test plan
- **Write:** setup `paddr=0x12008`, `pwdata=0xA5A5_0001`, `pstrb=0xF`; `i_req_ready=1` immediately; `i_resp_valid` one cycle later with `err=0`.
  - Expect `o_req_addr=0x008`, `o_req_wstrb=0xF`.
  - Expect `pready` pulse at cycle 3 with `pslverr=0`.
- **Read:** `paddr=0x10004`; response `rdata=0xDEADBEEF`, `err=0`.
  - Expect `prdata=0xDEADBEEF` for exactly one `pready` cycle.
  - Expect `o_req_wstrb=0`.
- **Backpressure:** `i_req_ready` held low 5 cycles.
  - Expect `o_req_valid` high and fields stable for all 5 cycles.
  - Expect `pready` 2 cycles after the handshake.
- **Slave error:** `i_resp_err=1` on a read with `rdata=0x1234`.
  - Expect `pslverr=1` and `prdata=0x1234`.
- **Timeout then late response:** `timeout=8`, no response.
  - Expect `pslverr=1`, `prdata=0` at cycle 10.
  - Start the next transfer: expect `o_req_valid=0` until a stale `i_resp_valid` arrives, then the new request proceeds normally.
  - Also cover `i_resp_valid` arriving in the expiry cycle: expect normal completion with no error.
- **Reset mid-WAIT_RESP:** assert `i_nrst=0` for one cycle.
  - Expect all outputs 0 and state IDLE.
  - A following transfer completes normally, and no spurious `pready` appears from the aborted transfer.
